// File: rtl/matrix_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// matrix_scan_driver_pkg
// Shared definitions for the LED matrix scan path. The compositor upstream
// uses the same row type, so a row vector means the same thing on both sides:
// bit k = column k, 1 = cell occupied.
// ---------------------------------------------------------------------------
package matrix_scan_driver_pkg;

    localparam int N_ROWS = 7;
    localparam int N_COLS = 7;

    // One composited board row.
    typedef logic [N_COLS-1:0] row_t;

    // Idle drive levels: no row selected, all (active-low) columns released.
    localparam row_t ROWS_OFF = '0;
    localparam row_t COLS_OFF = '1;

    // One-hot row select for row index idx (0..N_ROWS-1).
    function automatic row_t onehot(input logic [2:0] idx);
        onehot = row_t'(1) << idx;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
// Row/slot sequencer for the matrix scan. Owns the row index r (0..6) and the
// slot cycle c (0..ROW_CYCLES-1), flags the frame-load edge and decodes
// whether the *next* cycle is inside the lit window. Everything it exports is
// next-state so the parent can register outputs with zero lag.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   brightness   3-bit duty select, sampled every cycle
//   r_nxt        row index after the coming edge
//   lit_nxt      1 = cycle after the coming edge is lit
//   frame_load   1 = the coming edge moves (6,ROW_CYCLES-1) -> (0,0)
//
// ROW_CYCLES >= 10; ROW_CYCLES-BLANK_CYCLES must be a nonzero multiple of 8.
// ---------------------------------------------------------------------------
module scan_timer
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROW_CYCLES   = 20,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] brightness,
    output logic [2:0] r_nxt,
    output logic       lit_nxt,
    output logic       frame_load
);

    localparam int CW = $clog2(ROW_CYCLES);
    // Cycles per brightness step; eight steps fill the on-phase exactly.
    localparam int P = (ROW_CYCLES - BLANK_CYCLES) / 8;
    localparam logic [CW-1:0] C_LAST = CW'(ROW_CYCLES - 1);
    localparam logic [2:0]    R_LAST = 3'(N_ROWS - 1);

    logic [2:0]    r;
    logic [CW-1:0] c;
    logic [CW-1:0] c_nxt;
    logic          slot_end;
    int            c_int;
    int            window;

    always_comb begin
        slot_end   = (c == C_LAST);
        frame_load = slot_end && (r == R_LAST);
        c_nxt      = slot_end ? '0 : c + CW'(1);
        r_nxt      = r;
        if (slot_end) begin
            r_nxt = (r == R_LAST) ? 3'd0 : r + 3'd1;
        end
    end

    // Lit window: skip the blanking lead-in, then stay on for
    // (brightness+1) steps of P cycles. Decoded on c_nxt so the registered
    // outputs line up with the counter state they describe.
    always_comb begin
        c_int   = int'(c_nxt);
        window  = (int'(brightness) + 1) * P;
        lit_nxt = (c_int >= BLANK_CYCLES) && ((c_int - BLANK_CYCLES) < window);
    end

    // Reset parks the counters on the last cycle of row 6 so the first edge
    // after release is always a frame-load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= R_LAST;
            c <= C_LAST;
        end else begin
            r <= r_nxt;
            c <= c_nxt;
        end
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// ---------------------------------------------------------------------------
// matrix_scan_driver
// Captures the seven composited rows into a shadow frame at each frame
// boundary and scans them onto a 7x7 LED matrix one row at a time, with
// leading blanking per row slot and 3-bit PWM brightness. Loading only at the
// boundary keeps a moving piece from tearing across a refresh.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   row_0 .. row_6    composited rows, bit k = column k, 1 = occupied
//   hold              1 = keep current shadow at the next frame boundary
//   brightness        lit fraction of on-phase = (brightness+1)/8
//   row_sel           one-hot active-high row drive (registered)
//   col_n             active-low column drive (registered)
//   frame_start       one-cycle pulse on the first cycle of row 0's slot
// ---------------------------------------------------------------------------
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROW_CYCLES   = 20,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] row_0,
    input  logic [6:0] row_1,
    input  logic [6:0] row_2,
    input  logic [6:0] row_3,
    input  logic [6:0] row_4,
    input  logic [6:0] row_5,
    input  logic [6:0] row_6,
    input  logic       hold,
    input  logic [2:0] brightness,
    output logic [6:0] row_sel,
    output logic [6:0] col_n,
    output logic       frame_start
);

    logic [2:0] r_nxt;
    logic       lit_nxt;
    logic       frame_load;

    row_t [N_ROWS-1:0] rows_in;
    row_t [N_ROWS-1:0] shadow;
    row_t [N_ROWS-1:0] shadow_nxt;

    scan_timer #(
        .ROW_CYCLES   (ROW_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .r_nxt      (r_nxt),
        .lit_nxt    (lit_nxt),
        .frame_load (frame_load)
    );

    assign rows_in = {row_6, row_5, row_4, row_3, row_2, row_1, row_0};

    always_comb begin
        shadow_nxt = shadow;
        if (frame_load && !hold) begin
            shadow_nxt = rows_in;
        end
    end

    // Outputs come straight from flops, decoded from next-state row/lit and
    // next-state shadow, so the freshly loaded frame is visible on row 0
    // without a one-cycle stale glimpse of the old one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            row_sel     <= ROWS_OFF;
            col_n       <= COLS_OFF;
            frame_start <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            row_sel     <= lit_nxt ? onehot(r_nxt) : ROWS_OFF;
            col_n       <= lit_nxt ? ~shadow_nxt[r_nxt] : COLS_OFF;
            frame_start <= frame_load;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_matrix_scan_driver
// Directed bench for matrix_scan_driver at default parameters (20/4).
// cyc counts frame cycles from the first post-release edge (cyc 0 = first
// cycle of row 0). A background monitor checks blanking and one-hotness on
// every running cycle.
// ---------------------------------------------------------------------------
module tb_matrix_scan_driver;
    import matrix_scan_driver_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] row_0, row_1, row_2, row_3, row_4, row_5, row_6;
    logic       hold;
    logic [2:0] brightness;
    logic [6:0] row_sel;
    logic [6:0] col_n;
    logic       frame_start;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = -1;
    bit mon_en = 1'b0;

    matrix_scan_driver #(.ROW_CYCLES(20), .BLANK_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_0       (row_0),
        .row_1       (row_1),
        .row_2       (row_2),
        .row_3       (row_3),
        .row_4       (row_4),
        .row_5       (row_5),
        .row_6       (row_6),
        .hold        (hold),
        .brightness  (brightness),
        .row_sel     (row_sel),
        .col_n       (col_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to frame cycle n; outputs are then sampled at the negedge.
    task automatic run_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_rst();
        rst    = 1'b0;
        cyc    = -1;
        mon_en = 1'b1;
    endtask

    // Every slot: cycles 0..3 dark, cycle 4 lit on the right row (the
    // narrowest window still covers c=4), never more than one row driven.
    always @(negedge clk) begin
        #1;
        if (mon_en && !rst && cyc >= 0) begin
            chk("multi_hot", {6'd0, ($countones(row_sel) <= 1)}, 7'd1);
            if ((cyc % 20) < 4)
                chk("slot_blank", row_sel, 7'h00);
            else if ((cyc % 20) == 4)
                chk("slot_first_lit", row_sel, onehot(3'((cyc / 20) % 7)));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        row_0 = 7'h55; row_1 = 7'h00; row_2 = 7'h00; row_3 = 7'h7F;
        row_4 = 7'h00; row_5 = 7'h00; row_6 = 7'h00;
        hold = 1'b0; brightness = 3'd7;

        repeat (3) @(negedge clk);
        chk("rst_row_sel", row_sel, 7'h00);
        chk("rst_col_n",   col_n,   7'h7F);
        chk("rst_fs",      {6'd0, frame_start}, 7'd0);

        // First frame: row 0 = 55 at full brightness.
        release_rst();
        run_to(0);
        chk("f0_fs",        {6'd0, frame_start}, 7'd1);
        chk("f0_c0_rs",     row_sel, 7'h00);
        chk("f0_c0_cn",     col_n,   7'h7F);
        run_to(3);
        chk("f0_c3_rs",     row_sel, 7'h00);
        chk("f0_c3_cn",     col_n,   7'h7F);
        chk("f0_c3_fs",     {6'd0, frame_start}, 7'd0);
        run_to(4);
        chk("f0_c4_rs",     row_sel, 7'h01);
        chk("f0_c4_cn",     col_n,   7'h2A);
        run_to(19);
        chk("f0_c19_rs",    row_sel, 7'h01);
        chk("f0_c19_cn",    col_n,   7'h2A);
        run_to(20);
        chk("f0_c20_rs",    row_sel, 7'h00);
        chk("f0_c20_cn",    col_n,   7'h7F);

        // Minimum brightness: row 3 lit only at c=4,5.
        brightness = 3'd0;
        run_to(64);
        chk("b0_c4_rs",     row_sel, 7'h08);
        chk("b0_c4_cn",     col_n,   7'h00);
        run_to(65);
        chk("b0_c5_rs",     row_sel, 7'h08);
        chk("b0_c5_cn",     col_n,   7'h00);
        run_to(66);
        chk("b0_c6_rs",     row_sel, 7'h00);
        chk("b0_c6_cn",     col_n,   7'h7F);
        run_to(79);
        chk("b0_c19_rs",    row_sel, 7'h00);

        // Load row_0=01 at the next boundary, then change mid-frame.
        run_to(80);
        brightness = 3'd7;
        row_0 = 7'h01;
        row_3 = 7'h00;
        run_to(139);
        chk("f1_pre_fs",    {6'd0, frame_start}, 7'd0);
        run_to(140);
        chk("f1_fs",        {6'd0, frame_start}, 7'd1);
        run_to(144);
        chk("f1_r0_cn",     col_n,   7'h7E);
        chk("f1_r0_rs",     row_sel, 7'h01);
        run_to(190);
        row_0 = 7'h40;
        run_to(279);
        chk("f2_pre_fs",    {6'd0, frame_start}, 7'd0);
        run_to(280);
        chk("f2_fs",        {6'd0, frame_start}, 7'd1);
        run_to(284);
        chk("f2_r0_cn",     col_n,   7'h3F);

        // Hold across one boundary: old pattern repeats, frame_start still pulses.
        run_to(290);
        row_0 = 7'h0F;
        hold  = 1'b1;
        run_to(420);
        chk("hold_fs",      {6'd0, frame_start}, 7'd1);
        run_to(424);
        chk("hold_r0_cn",   col_n,   7'h3F);
        run_to(430);
        hold  = 1'b0;
        row_3 = 7'h7F;
        run_to(500);
        hold  = 1'b1;
        run_to(501);
        hold  = 1'b0;
        run_to(560);
        chk("unhold_fs",    {6'd0, frame_start}, 7'd1);
        run_to(564);
        chk("unhold_r0_cn", col_n,   7'h70);

        // Asynchronous reset at frame cycle 77 (row 3 lit).
        run_to(637);
        chk("pre_rst_rs",   row_sel, 7'h08);
        chk("pre_rst_cn",   col_n,   7'h00);
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("async_rs",     row_sel, 7'h00);
        chk("async_cn",     col_n,   7'h7F);
        chk("async_fs",     {6'd0, frame_start}, 7'd0);
        row_0 = 7'h12;
        repeat (2) @(negedge clk);
        release_rst();
        run_to(0);
        chk("rr_fs",        {6'd0, frame_start}, 7'd1);
        run_to(4);
        chk("rr_r0_rs",     row_sel, 7'h01);
        chk("rr_r0_cn",     col_n,   7'h6D);

        // Reset with hold=1: first frame shows the cleared shadow.
        run_to(10);
        rst    = 1'b1;
        mon_en = 1'b0;
        hold   = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();
        run_to(0);
        chk("clr_fs",       {6'd0, frame_start}, 7'd1);
        run_to(4);
        chk("clr_r0_rs",    row_sel, 7'h01);
        chk("clr_r0_cn",    col_n,   7'h7F);
        run_to(64);
        chk("clr_r3_cn",    col_n,   7'h7F);
        hold = 1'b0;
        run_to(140);
        chk("clr_next_fs",  {6'd0, frame_start}, 7'd1);
        run_to(144);
        chk("clr_next_cn",  col_n,   7'h6D);
        run_to(150);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
